// File: rtl/arb_sram_bridge_pkg.sv
// arb_sram_bridge_pkg: shared state encoding and marker word layout for the SRAM bridge
package arb_sram_bridge_pkg;
  typedef enum logic [1:0] {PASS = 2'd0, MARK = 2'd1, DROP = 2'd2} state_t;
  localparam int MARK_ID_MSB = 31;
  localparam int MARK_ID_LSB = 28;
  localparam int MARK_CNT_W = 16;
  localparam logic [3:0] MARK_ID_DEF = 4'hF;
  function automatic logic [31:0] mark_word(input logic [3:0] id, input logic [MARK_CNT_W-1:0] n);
    logic [31:0] w;
    w = '0;
    w[MARK_ID_MSB:MARK_ID_LSB] = id;
    w[MARK_CNT_W-1:0] = n;
    return w;
  endfunction
endpackage

// File: rtl/arb_sram_bridge_if.sv
// arb_sram_bridge_if: arbiter-side, SRAM-FIFO-side and status signals of the bridge
interface arb_sram_bridge_if;
  logic        DROP_EN;
  logic        IN_VALID;
  logic [31:0] IN_DATA;
  logic        IN_READ;
  logic        OUT_READ_NEXT;
  logic        OUT_EMPTY;
  logic [31:0] OUT_DATA;
  logic        FIFO_FULL;
  logic [7:0]  LOST_CNT;
  logic        OVERFLOW;
  modport master (
    output DROP_EN, IN_VALID, IN_DATA, OUT_READ_NEXT, FIFO_FULL,
    input  IN_READ, OUT_EMPTY, OUT_DATA, LOST_CNT, OVERFLOW
  );
  modport slave (
    input  DROP_EN, IN_VALID, IN_DATA, OUT_READ_NEXT, FIFO_FULL,
    output IN_READ, OUT_EMPTY, OUT_DATA, LOST_CNT, OVERFLOW
  );
endinterface

// File: rtl/arb_sram_bridge_sfifo.sv
// bridge_sfifo: show-ahead synchronous circular FIFO with count
module bridge_sfifo #(
  parameter int DEPTH = 8,
  parameter int ABITS = 3,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic           full,
  output logic           empty,
  output logic [ABITS:0] count
);
  localparam int CW = ABITS + 1;
  logic [W-1:0] mem [DEPTH];
  logic [ABITS-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/arb_sram_bridge.sv
// arb_sram_bridge: elastic arbiter-to-SRAM-FIFO bridge with drop mode and lost-word marker
module arb_sram_bridge
  import arb_sram_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ABITS = 3,
  parameter logic [3:0] MARK_ID = MARK_ID_DEF
) (
  input logic BUS_CLK,
  input logic BUS_RST_B,
  arb_sram_bridge_if.slave bus
);
  localparam logic [ABITS:0] DEPTH_C = (ABITS + 1)'(DEPTH);
  state_t state_q, state_d;
  logic [MARK_CNT_W-1:0] ep_cnt, ep_nxt;
  logic [7:0] lost_cnt;
  logic [ABITS:0] count;
  logic [31:0] din;
  logic overflow, in_read, push, drop, full, empty;
  assign drop = state_q == DROP && bus.IN_VALID;
  assign ep_nxt = drop && ep_cnt != '1 ? ep_cnt + 1'b1 : ep_cnt;
  always_comb begin
    state_d = state_q;
    in_read = 1'b0;
    push = 1'b0;
    din = bus.IN_DATA;
    case (state_q)
      PASS: begin
        in_read = bus.IN_VALID && count < DEPTH_C;
        push = in_read;
        state_d = bus.FIFO_FULL && bus.DROP_EN ? DROP : PASS;
      end
      DROP: begin
        in_read = bus.IN_VALID;
        state_d = !bus.FIFO_FULL || !bus.DROP_EN ? (ep_nxt != '0 ? MARK : PASS) : DROP;
      end
      MARK: begin
        push = !full;
        din = mark_word(MARK_ID, ep_cnt);
        state_d = full ? MARK : PASS;
      end
      default: state_d = PASS;
    endcase
  end
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B)
    if (!BUS_RST_B) begin
      state_q <= PASS;
      ep_cnt <= '0;
      lost_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      ep_cnt <= state_q == MARK && !full ? '0 : ep_nxt;
      lost_cnt <= drop && lost_cnt != 8'hFF ? lost_cnt + 1'b1 : lost_cnt;
      overflow <= overflow | drop;
    end
  bridge_sfifo #(.DEPTH(DEPTH), .ABITS(ABITS), .W(32)) u_fifo (
    .clk(BUS_CLK),
    .rst_n(BUS_RST_B),
    .push(push),
    .pop(bus.OUT_READ_NEXT),
    .din(din),
    .dout(bus.OUT_DATA),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.IN_READ = BUS_RST_B && in_read;
  assign bus.OUT_EMPTY = empty;
  assign bus.LOST_CNT = lost_cnt;
  assign bus.OVERFLOW = overflow;
endmodule

// File: tb/tb_arb_sram_bridge.sv
// tb_arb_sram_bridge: directed self-checking bench for arb_sram_bridge
module tb_arb_sram_bridge;
  import arb_sram_bridge_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int acc = 0;
  logic [31:0] wd;
  logic [31:0] outq[$];
  arb_sram_bridge_if bus();
  arb_sram_bridge #(.DEPTH(8), .ABITS(3), .MARK_ID(4'hF)) dut (
    .BUS_CLK(clk),
    .BUS_RST_B(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    #1;
    if (bus.IN_VALID && bus.IN_READ) begin
      acc++;
      wd = wd + 1;
    end
    if (bus.OUT_READ_NEXT && !bus.OUT_EMPTY) outq.push_back(bus.OUT_DATA);
    @(posedge clk);
    #1;
    bus.IN_DATA = wd;
  endtask
  task automatic start(input logic [31:0] w);
    wd = w;
    bus.IN_DATA = w;
    acc = 0;
    outq.delete();
  endtask
  task automatic test_reset();
    bus.DROP_EN = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA = '0;
    bus.OUT_READ_NEXT = 1'b0;
    bus.FIFO_FULL = 1'b0;
    #3;
    total_cnt++; if (bus.IN_READ !== 1'b0) $display("FAIL reset_in_read got %b exp 0", bus.IN_READ); else pass_cnt++;
    total_cnt++; if (bus.OUT_EMPTY !== 1'b1) $display("FAIL reset_out_empty got %b exp 1", bus.OUT_EMPTY); else pass_cnt++;
    total_cnt++; if (bus.OUT_DATA !== 32'h0) $display("FAIL reset_out_data got %h exp 0", bus.OUT_DATA); else pass_cnt++;
    total_cnt++; if (bus.LOST_CNT !== 8'h0) $display("FAIL reset_lost_cnt got %h exp 0", bus.LOST_CNT); else pass_cnt++;
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL reset_overflow got %b exp 0", bus.OVERFLOW); else pass_cnt++;
    total_cnt++; if (dut.state_q !== PASS) $display("FAIL reset_state got %0d exp PASS", dut.state_q); else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_stream();
    logic [31:0] g;
    start(32'd1);
    bus.DROP_EN = 1'b0;
    bus.FIFO_FULL = 1'b0;
    bus.OUT_READ_NEXT = 1'b1;
    bus.IN_VALID = 1'b1;
    #1;
    total_cnt++; if (bus.OUT_EMPTY !== 1'b1) $display("FAIL stream_empty_before got %b exp 1", bus.OUT_EMPTY); else pass_cnt++;
    tick();
    total_cnt++; if (bus.OUT_EMPTY !== 1'b0) $display("FAIL stream_empty_after_push got %b exp 0", bus.OUT_EMPTY); else pass_cnt++;
    total_cnt++; if (bus.OUT_DATA !== 32'd1) $display("FAIL stream_first_word got %h exp 1", bus.OUT_DATA); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      bus.IN_VALID = wd <= 32'd20;
      tick();
    end
    total_cnt++; if (outq.size() != 20) $display("FAIL stream_count got %0d exp 20", outq.size()); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      g = i < outq.size() ? outq[i] : 'x;
      total_cnt++; if (g !== 32'(i + 1)) $display("FAIL stream_word[%0d] got %h exp %h", i, g, i + 1); else pass_cnt++;
    end
    total_cnt++; if (bus.LOST_CNT !== 8'h0) $display("FAIL stream_lost got %h exp 0", bus.LOST_CNT); else pass_cnt++;
  endtask
  task automatic test_backpressure();
    logic [31:0] g;
    start(32'h101);
    bus.DROP_EN = 1'b0;
    bus.FIFO_FULL = 1'b0;
    bus.OUT_READ_NEXT = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.IN_VALID = wd <= 32'h10C;
      tick();
    end
    total_cnt++; if (acc !== 8) $display("FAIL bp_accepted got %0d exp 8", acc); else pass_cnt++;
    total_cnt++; if (bus.IN_READ !== 1'b0) $display("FAIL bp_in_read got %b exp 0", bus.IN_READ); else pass_cnt++;
    total_cnt++; if (bus.OUT_DATA !== 32'h101) $display("FAIL bp_head_hold got %h exp 101", bus.OUT_DATA); else pass_cnt++;
    bus.FIFO_FULL = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++; if (acc !== 8) $display("FAIL bp_full_accepted got %0d exp 8", acc); else pass_cnt++;
    total_cnt++; if (bus.LOST_CNT !== 8'h0) $display("FAIL bp_full_lost got %h exp 0", bus.LOST_CNT); else pass_cnt++;
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL bp_full_overflow got %b exp 0", bus.OVERFLOW); else pass_cnt++;
    bus.OUT_READ_NEXT = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.IN_VALID = wd <= 32'h10C;
      tick();
    end
    total_cnt++; if (outq.size() != 12) $display("FAIL bp_count got %0d exp 12", outq.size()); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      g = i < outq.size() ? outq[i] : 'x;
      total_cnt++; if (g !== 32'h101 + 32'(i)) $display("FAIL bp_word[%0d] got %h exp %h", i, g, 32'h101 + 32'(i)); else pass_cnt++;
    end
    bus.FIFO_FULL = 1'b0;
  endtask
  task automatic test_drop();
    logic [31:0] e[$];
    logic [31:0] g;
    e = '{32'h201, 32'hF0000005, 32'h207, 32'h208, 32'h209, 32'h20A};
    start(32'h201);
    bus.DROP_EN = 1'b1;
    bus.OUT_READ_NEXT = 1'b1;
    bus.FIFO_FULL = 1'b1;
    bus.IN_VALID = 1'b1;
    tick();
    total_cnt++; if (bus.LOST_CNT !== 8'h0) $display("FAIL drop_first_edge_lost got %h exp 0", bus.LOST_CNT); else pass_cnt++;
    tick();
    total_cnt++; if (bus.LOST_CNT !== 8'h1) $display("FAIL drop_second_edge_lost got %h exp 1", bus.LOST_CNT); else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    bus.FIFO_FULL = 1'b0;
    bus.IN_VALID = 1'b0;
    tick();
    total_cnt++; if (bus.LOST_CNT !== 8'h5) $display("FAIL drop_lost got %h exp 5", bus.LOST_CNT); else pass_cnt++;
    total_cnt++; if (bus.OVERFLOW !== 1'b1) $display("FAIL drop_overflow got %b exp 1", bus.OVERFLOW); else pass_cnt++;
    bus.IN_VALID = 1'b1;
    #1;
    total_cnt++; if (bus.IN_READ !== 1'b0) $display("FAIL drop_mark_in_read got %b exp 0", bus.IN_READ); else pass_cnt++;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.IN_VALID = wd <= 32'h20A;
      tick();
    end
    total_cnt++; if (outq.size() != e.size()) $display("FAIL drop_count got %0d exp %0d", outq.size(), e.size()); else pass_cnt++;
    for (int i = 0; i < e.size(); i++) begin
      g = i < outq.size() ? outq[i] : 'x;
      total_cnt++; if (g !== e[i]) $display("FAIL drop_word[%0d] got %h exp %h", i, g, e[i]); else pass_cnt++;
    end
  endtask
  task automatic test_mark_full();
    logic [31:0] e[$];
    logic [31:0] g;
    e = '{32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306, 32'h307, 32'h308,
          32'hF0000003, 32'h30C, 32'h30D, 32'h30E};
    start(32'h301);
    bus.DROP_EN = 1'b1;
    bus.FIFO_FULL = 1'b0;
    bus.OUT_READ_NEXT = 1'b0;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    total_cnt++; if (acc !== 8) $display("FAIL mf_fill got %0d exp 8", acc); else pass_cnt++;
    bus.FIFO_FULL = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.FIFO_FULL = 1'b0;
    bus.IN_VALID = 1'b0;
    tick();
    bus.IN_VALID = 1'b1;
    tick();
    tick();
    total_cnt++; if (acc !== 11) $display("FAIL mf_mark_wait_accepted got %0d exp 11", acc); else pass_cnt++;
    total_cnt++; if (bus.IN_READ !== 1'b0) $display("FAIL mf_mark_in_read got %b exp 0", bus.IN_READ); else pass_cnt++;
    total_cnt++; if (bus.OUT_DATA !== 32'h301) $display("FAIL mf_head got %h exp 301", bus.OUT_DATA); else pass_cnt++;
    bus.OUT_READ_NEXT = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.IN_VALID = wd <= 32'h30E;
      tick();
    end
    total_cnt++; if (bus.LOST_CNT !== 8'd8) $display("FAIL mf_lost got %h exp 08", bus.LOST_CNT); else pass_cnt++;
    total_cnt++; if (outq.size() != e.size()) $display("FAIL mf_count got %0d exp %0d", outq.size(), e.size()); else pass_cnt++;
    for (int i = 0; i < e.size(); i++) begin
      g = i < outq.size() ? outq[i] : 'x;
      total_cnt++; if (g !== e[i]) $display("FAIL mf_word[%0d] got %h exp %h", i, g, e[i]); else pass_cnt++;
    end
  endtask
  task automatic test_saturation();
    logic [31:0] e[$];
    logic [31:0] g;
    e = '{32'h401, 32'hF000012C, 32'h52E, 32'h52F};
    start(32'h401);
    bus.DROP_EN = 1'b1;
    bus.OUT_READ_NEXT = 1'b1;
    bus.FIFO_FULL = 1'b1;
    bus.IN_VALID = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) tick();
    total_cnt++; if (bus.LOST_CNT !== 8'hFF) $display("FAIL sat_lost got %h exp ff", bus.LOST_CNT); else pass_cnt++;
    bus.FIFO_FULL = 1'b0;
    bus.IN_VALID = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.IN_VALID = wd <= 32'h52F;
      tick();
    end
    total_cnt++; if (outq.size() != e.size()) $display("FAIL sat_count got %0d exp %0d", outq.size(), e.size()); else pass_cnt++;
    for (int i = 0; i < e.size(); i++) begin
      g = i < outq.size() ? outq[i] : 'x;
      total_cnt++; if (g !== e[i]) $display("FAIL sat_word[%0d] got %h exp %h", i, g, e[i]); else pass_cnt++;
    end
  endtask
  task automatic test_async_reset();
    logic [31:0] g;
    start(32'h601);
    bus.DROP_EN = 1'b1;
    bus.FIFO_FULL = 1'b0;
    bus.OUT_READ_NEXT = 1'b0;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.FIFO_FULL = 1'b1;
    tick();
    tick();
    total_cnt++; if (dut.state_q !== DROP) $display("FAIL ar_pre_state got %0d exp DROP", dut.state_q); else pass_cnt++;
    total_cnt++; if (acc !== 5) $display("FAIL ar_pre_accepted got %0d exp 5", acc); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.OUT_EMPTY !== 1'b1) $display("FAIL ar_out_empty got %b exp 1", bus.OUT_EMPTY); else pass_cnt++;
    total_cnt++; if (bus.OUT_DATA !== 32'h0) $display("FAIL ar_out_data got %h exp 0", bus.OUT_DATA); else pass_cnt++;
    total_cnt++; if (bus.LOST_CNT !== 8'h0) $display("FAIL ar_lost got %h exp 0", bus.LOST_CNT); else pass_cnt++;
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL ar_overflow got %b exp 0", bus.OVERFLOW); else pass_cnt++;
    total_cnt++; if (bus.IN_READ !== 1'b0) $display("FAIL ar_in_read got %b exp 0", bus.IN_READ); else pass_cnt++;
    total_cnt++; if (dut.state_q !== PASS) $display("FAIL ar_state got %0d exp PASS", dut.state_q); else pass_cnt++;
    #2;
    rst_n = 1'b1;
    start(32'h701);
    bus.FIFO_FULL = 1'b0;
    bus.OUT_READ_NEXT = 1'b1;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.IN_VALID = wd <= 32'h701;
      tick();
    end
    total_cnt++; if (outq.size() != 1) $display("FAIL ar_post_count got %0d exp 1", outq.size()); else pass_cnt++;
    g = outq.size() > 0 ? outq[0] : 'x;
    total_cnt++; if (g !== 32'h701) $display("FAIL ar_post_word got %h exp 701", g); else pass_cnt++;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0t", $time);
    $fatal(1);
  end
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drop();
    test_mark_full();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
